fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, width of the FIFO read data and the output data.
REQ-002 SHALL provide parameter CNT_WIDTH, default 8, width of the delivered-word counter.
REQ-003 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port en  input  1  run enable; 1 = fetch from the FIFO, 0 = stop fetching and drain.
REQ-006 SHALL provide port fifo_empty  input  1  registered empty flag from the upstream FIFO.
REQ-007 SHALL provide port fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid the cycle after a read.
REQ-008 SHALL provide port fifo_rd  output  1  read strobe to the upstream FIFO; one word per asserted cycle.
REQ-009 SHALL provide port out_ready  input  1  downstream can accept a word this cycle.
REQ-010 SHALL provide port out_valid  output  1  out_data holds a valid word.
REQ-011 SHALL provide port out_data  output  DATA_WIDTH  word presented downstream, the head of the skid buffer.
REQ-012 SHALL provide port busy  output  1  high in RUN or DRAIN.
REQ-013 SHALL provide port words_out  output  CNT_WIDTH  count of completed output transfers; wraps modulo 2^CNT_WIDTH.

Function
REQ-014 SHALL contain a 2-entry in-order skid buffer with occupancy count (0..2) and an inflight flag (registered copy of fifo_rd).
REQ-015 SHALL capture fifo_data into the buffer tail on every cycle where inflight=1; the read latency is exactly 1 cycle.
REQ-016 SHALL assert out_valid iff the count is greater than 0; out_data SHALL be the oldest entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL complete a transfer on a cycle with out_valid=1 and out_ready=1, then pop the head and increment words_out by 1.
REQ-018 SHALL compute used = count + inflight - (out_valid & out_ready).
REQ-019 SHALL drive fifo_rd = (state==RUN) & en & !fifo_empty & (used < 2); a combinational path from out_ready to fifo_rd is permitted.
REQ-020 SHALL never overflow the buffer: a capture and a pop in the same cycle leave the count unchanged, and a capture with the count at 2 is impossible by REQ-019.
REQ-021 SHALL sustain 1 word/cycle throughput when fifo_empty=0 and out_ready=1 continuously.
REQ-022 SHALL implement the state machine as follows:
  - IDLE: en=1 -> RUN.
  - RUN: en=0 and (count+inflight)>0 -> DRAIN; en=0 and nothing held -> IDLE.
  - DRAIN: en=1 -> RUN; the next-cycle count+inflight equal to 0 -> IDLE.
REQ-023 SHALL issue no fifo_rd in IDLE or DRAIN; DRAIN SHALL still capture an inflight word and keep delivering buffered words.
REQ-024 SHALL drive busy = (state != IDLE).
REQ-025 SHALL preserve strict FIFO order across backpressure, en toggling and the empty boundary.
REQ-026 SHALL ignore fifo_data on cycles where inflight=0.

Reset
REQ-027 SHALL, while reset=0 and independent of clk, set state=IDLE, count=0, inflight=0, words_out=0, out_valid=0, out_data=0 and busy=0; fifo_rd SHALL be 0.
REQ-028 SHALL discard any read inflight at reset assertion, and any buffered words, with no capture on the first edge after release.
REQ-029 SHALL keep all outputs at their reset values on the first clock edge after reset deasserts; fetching SHALL begin no earlier than the cycle after entering RUN.

Verification
REQ-030 SHALL verify streaming: FIFO holds 0x11,0x22,0x33, en=1, out_ready=1 -> fifo_rd is high 3 consecutive cycles, out_data is 0x11,0x22,0x33 on consecutive cycles, and words_out=3.
REQ-031 SHALL verify backpressure: out_ready=0 with 5 words available -> exactly 2 reads are issued, out_valid=1 and out_data=first word held stable; after out_ready=1 all 5 words arrive in order.
REQ-032 SHALL verify empty boundary: the FIFO empties after 1 word -> a single fifo_rd is issued, no read occurs while fifo_empty=1, and out_valid drops after the transfer.
REQ-033 SHALL verify drain: en falls with 2 words buffered and out_ready=1 -> state is DRAIN, busy=1, no fifo_rd, both words are delivered, then IDLE and busy=0.
REQ-034 SHALL verify mid-operation reset: reset=0 asynchronously with an inflight read and 1 word buffered -> out_valid=0 and words_out=0 immediately, and no capture occurs after release.
REQ-035 SHALL verify counter wrap: 256 transfers with CNT_WIDTH=8 -> words_out returns to 0x00.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between the read controller, the upstream FIFO read port
// and the downstream valid/ready consumer.
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // Controller side: issues reads upstream and presents words downstream.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_ready,
        output fifo_rd,
        output out_valid,
        output out_data
    );

    // Environment side: the FIFO and the consumer.
    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_ready,
        input  fifo_rd,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: fetches words from a registered-output FIFO (1-cycle
// read latency) into a 2-entry skid buffer and streams them downstream over a
// valid/ready handshake at up to one word per cycle.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    fifo_rd_ctrl_if.master       bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_out
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic                  armed;     // low only until the first edge after reset release
    logic [1:0]            count;     // skid buffer occupancy, 0..2
    logic                  inflight;  // a read was issued last cycle; its data arrives now
    logic [DATA_WIDTH-1:0] head;      // oldest buffered word
    logic [DATA_WIDTH-1:0] tail;      // second word, valid when count == 2
    logic                  pop;
    logic [1:0]            used;      // occupancy after this cycle's capture and pop

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head;
    assign pop           = bus.out_valid & bus.out_ready;
    // Never underflows: pop implies count >= 1. Maximum is 2 + 1 = 3.
    assign used          = count + {1'b0, inflight} - {1'b0, pop};

    // A read is only issued if its word is guaranteed a buffer slot next cycle.
    assign bus.fifo_rd = (state == RUN) & en & ~bus.fifo_empty & (used < 2'd2);

    // Control state machine; busy is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    // Held off for one edge after reset so outputs stay quiet.
                    if (en && armed) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        if ((count != 2'd0) || inflight) begin
                            state <= DRAIN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // No reads in DRAIN, so next-cycle holdings equal used.
                    if (en) begin
                        state <= RUN;
                    end else if (used == 2'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skid buffer: capture the returning read word at the tail, pop the head on transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= bus.fifo_rd;
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= bus.fifo_data;
                    end else begin
                        tail <= bus.fifo_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy unchanged, order kept.
                    if (count == 2'd1) begin
                        head <= bus.fifo_data;
                    end else begin
                        head <= tail;
                        tail <= bus.fifo_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completed-transfer counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural upstream FIFO and an
// in-order scoreboard of words loaded into it.
module tb_fifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       busy;
    logic [7:0] words_out;

    fifo_rd_ctrl_if #(.DATA_WIDTH(8)) bus ();

    fifo_rd_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .bus       (bus),
        .busy      (busy),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] src[$];     // contents of the upstream FIFO
    logic [7:0] exp_q[$];   // words still owed downstream, in order
    logic [7:0] rd_hist;
    logic [7:0] xf_hist;
    int         rd_cnt;
    int         rd_empty_err = 0;
    int         unstable     = 0;
    logic       prev_stall   = 1'b0;
    logic [7:0] prev_data    = 8'h00;
    logic       rd_seen;
    logic       xf;
    logic [7:0] expw;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(logic [7:0] w);
        src.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock cycle: observe the handshake mid-cycle, then model the FIFO's
    // registered read port just after the rising edge.
    task automatic tick();
        @(negedge clk);
        rd_seen = bus.fifo_rd;
        xf      = bus.out_valid & bus.out_ready;
        rd_hist = {rd_hist[6:0], rd_seen};
        xf_hist = {xf_hist[6:0], xf};
        if (rd_seen) rd_cnt++;
        if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) unstable++;
        prev_stall = bus.out_valid & ~bus.out_ready;
        prev_data  = bus.out_data;
        if (xf) begin
            if (exp_q.size() == 0) begin
                check("spurious_xfer", 32'd1, 32'd0);
            end else begin
                expw = exp_q.pop_front();
                check("order", {24'd0, bus.out_data}, {24'd0, expw});
            end
        end
        @(posedge clk);
        #1;
        if (rd_seen && src.size() != 0) begin
            bus.fifo_data = src.pop_front();
        end else begin
            if (rd_seen) rd_empty_err++;
            bus.fifo_data = 8'($urandom);
        end
        bus.fifo_empty = (src.size() == 0);
    endtask

    task automatic run_until_empty(int bound, string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        reset          = 1'b0;
        en             = 1'b0;
        bus.out_ready  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = 8'h5a;
        rd_hist        = 8'h00;
        xf_hist        = 8'h00;
        rd_cnt         = 0;
        #2;
        // Reset state, before any clock edge
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_words_out", words_out, 0);
        check("rst_fifo_rd", bus.fifo_rd, 0);
        repeat (2) @(posedge clk);
        #1;

        // Streaming: three words at full rate
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        en            = 1'b1;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        tick();
        check("first_edge_busy", busy, 0);
        check("first_edge_rd", bus.fifo_rd, 0);
        check("first_edge_valid", bus.out_valid, 0);
        tick();
        rd_hist = 8'h00;
        xf_hist = 8'h00;
        repeat (6) tick();
        check("stream_rd_pattern", rd_hist[5:0], 6'b111000);
        check("stream_xfer_pattern", xf_hist[5:0], 6'b001110);
        check("stream_words_out", words_out, 3);
        check("stream_busy", busy, 1);

        // Backpressure: five words available, consumer stalled
        bus.out_ready = 1'b0;
        rd_cnt        = 0;
        for (int i = 0; i < 5; i++) push_word(8'hA1 + 8'(i));
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", bus.out_valid, 1);
            check("bp_head", bus.out_data, 8'hA1);
        end
        check("bp_reads", rd_cnt, 2);
        bus.out_ready = 1'b1;
        run_until_empty(40, "bp_drain");
        check("bp_words_out", words_out, 8);

        // Empty boundary: a single word then the FIFO runs dry
        rd_cnt = 0;
        push_word(8'h5C);
        repeat (5) tick();
        check("empty_reads", rd_cnt, 1);
        check("empty_valid_drop", bus.out_valid, 0);
        check("empty_words_out", words_out, 9);
        check("empty_no_rd", rd_empty_err, 0);

        // Drain: en falls with two words buffered
        bus.out_ready = 1'b0;
        rd_cnt        = 0;
        push_word(8'hB1); push_word(8'hB2); push_word(8'hB3); push_word(8'hB4);
        repeat (4) tick();
        check("drain_prefill_reads", rd_cnt, 2);
        en            = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("drain_busy", busy, 1);
        check("drain_no_rd", bus.fifo_rd, 0);
        check("drain_words_1", words_out, 10);
        tick();
        check("drain_idle_busy", busy, 0);
        check("drain_idle_valid", bus.out_valid, 0);
        check("drain_words_2", words_out, 11);
        check("drain_left_in_fifo", exp_q.size(), 2);
        en = 1'b1;
        run_until_empty(20, "drain_restart");
        check("drain_words_3", words_out, 13);

        // Mid-operation reset: one word buffered, one read in flight
        bus.out_ready = 1'b0;
        push_word(8'hC1); push_word(8'hC2); push_word(8'hC3);
        repeat (2) tick();
        check("pre_rst_valid", bus.out_valid, 1);
        reset      = 1'b0;
        prev_stall = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_words", words_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_data", bus.out_data, 0);
        exp_q.delete();
        foreach (src[i]) exp_q.push_back(src[i]);
        tick();
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_no_capture", bus.out_valid, 0);
        check("post_rst_busy", busy, 0);
        run_until_empty(20, "post_rst_drain");
        check("post_rst_words", words_out, 1);

        // Wrap: 255 more transfers bring the count back to zero, with random
        // backpressure and enable toggling
        for (int i = 0; i < 255; i++) push_word(8'($urandom));
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 3000) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                en            = ($urandom_range(0, 7) != 0);
                tick();
                n++;
            end
        end
        check("wrap_drain", exp_q.size(), 0);
        check("wrap_words_out", words_out, 0);
        check("no_rd_when_empty", rd_empty_err, 0);
        check("head_stable", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
